scan_xfer_ctrl: RTL and testbench

Downstream controller for the primary/alternate scanner pair. Watches each scanner's state, memory fill and ready flags, then grants downlink transfers one scanner at a time by driving each scanner's xfer input. It also registers the scanners' cross-coupled start-scan and go-to-standby requests and, optionally, accumulates downlinked data totals. One instance sits between the two scanners and the downlink interface.

---
 rtl/scan_xfer_ctrl_pkg.sv | 22 ++
 rtl/scan_xfer_ctrl_if.sv | 29 ++
 rtl/scan_xfer_rr_arb.sv | 18 +
 rtl/scan_xfer_ctrl.sv | 135 +++++++++++++
 tb/tb_scan_xfer_ctrl.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/scan_xfer_ctrl_pkg.sv
// scanner_pkg: scanner state encodings, controller FSM states and shared constants
package scanner_pkg;

  typedef enum logic [2:0] {
    LOW_PWR  = 3'b000,
    STBY     = 3'b001,
    SCANNING = 3'b010,
    IDLE     = 3'b011,
    FLUSHING = 3'b100,
    XFERRING = 3'b101
  } scan_state_e;

  typedef enum logic [1:0] {XC_IDLE, XC_GRANT, XC_XFER, XC_COOL} xc_state_e;

  localparam logic [7:0] MEM_FULL = 8'd100;

  // Memory fill never legitimately exceeds MEM_FULL; clamp stray values.
  function automatic logic [7:0] clamp_units(logic [7:0] m);
    return (m > MEM_FULL) ? MEM_FULL : m;
  endfunction

endpackage

// File: rtl/scan_xfer_ctrl_if.sv
// scan_xfer_ctrl_if: scanner-pair / downlink signal bundle seen by the transfer controller
interface scan_xfer_ctrl_if #(parameter int TOTAL_W = 16);
  import scanner_pkg::*;
  scan_state_e        state1, state2;
  logic [7:0]         mem_used1, mem_used2;
  logic               rdy_xfer1, rdy_xfer2;
  logic               start_scan_out1, start_scan_out2;
  logic               goto_stby_out1, goto_stby_out2;
  logic               downlink_ok;
  logic               xfer1, xfer2;
  logic               start_scan_in1, start_scan_in2;
  logic               goto_stby_in1, goto_stby_in2;
  logic               busy, active_sel, timeout_err;
  logic [TOTAL_W-1:0] xfer_total;

  modport master (
    output state1, state2, mem_used1, mem_used2, rdy_xfer1, rdy_xfer2,
           start_scan_out1, start_scan_out2, goto_stby_out1, goto_stby_out2, downlink_ok,
    input  xfer1, xfer2, start_scan_in1, start_scan_in2, goto_stby_in1, goto_stby_in2,
           busy, active_sel, timeout_err, xfer_total
  );

  modport slave (
    input  state1, state2, mem_used1, mem_used2, rdy_xfer1, rdy_xfer2,
           start_scan_out1, start_scan_out2, goto_stby_out1, goto_stby_out2, downlink_ok,
    output xfer1, xfer2, start_scan_in1, start_scan_in2, goto_stby_in1, goto_stby_in2,
           busy, active_sel, timeout_err, xfer_total
  );
endinterface

// File: rtl/scan_xfer_rr_arb.sv
// scan_xfer_rr_arb: two-requester round-robin picker; pointer remembers the last granted scanner
module scan_xfer_rr_arb (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  input  logic       upd_sel_i,
  output logic       valid_o,
  output logic       sel_o
);
  logic last_q;
  // Reset value 1 means "scanner 2 went last", so scanner 1 wins the first tie.
  always_ff @(posedge clk or negedge reset)
    if (!reset) last_q <= 1'b1;
    else if (upd_i) last_q <= upd_sel_i;
  assign valid_o = |req_i;
  assign sel_o   = &req_i ? ~last_q : req_i[1];
endmodule

// File: rtl/scan_xfer_ctrl.sv
// scan_xfer_ctrl: grants downlink transfers to one scanner at a time; SCAN_XFER_CTRL_STATS_EN adds the xfer_total accumulator
module scan_xfer_ctrl
  import scanner_pkg::*;
#(
  parameter int GRANT_TIMEOUT   = 15,
  parameter int COOLDOWN_CYCLES = 4,
  parameter int TOTAL_W         = 16
) (
  input logic             clk,
  input logic             reset,
  scan_xfer_ctrl_if.slave bus
);
  localparam int TW = $clog2(GRANT_TIMEOUT + 1);
  localparam int CW = $clog2(COOLDOWN_CYCLES + 1);

  xc_state_e   state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [CW-1:0] cool_q, cool_d;
  logic        sel_q, sel_d, x1_q, x1_d, x2_q, x2_d, to_q, to_d;
  logic        upd, arb_v, arb_sel;
  logic [3:0]  xc_q;
  scan_state_e cur;

  assign cur = sel_q ? bus.state2 : bus.state1;

  scan_xfer_rr_arb u_arb (
    .clk      (clk),
    .reset    (reset),
    .req_i    ({bus.rdy_xfer2 && bus.state2 == IDLE, bus.rdy_xfer1 && bus.state1 == IDLE}),
    .upd_i    (upd),
    .upd_sel_i(sel_q),
    .valid_o  (arb_v),
    .sel_o    (arb_sel)
  );

  // Next-state and registered-output decisions; pointer update fires on cooldown entry.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    cool_d  = cool_q;
    sel_d   = sel_q;
    x1_d    = x1_q;
    x2_d    = x2_q;
    to_d    = 1'b0;
    upd     = 1'b0;
    case (state_q)
      XC_IDLE:
        if (bus.downlink_ok && arb_v) begin
          state_d = XC_GRANT;
          sel_d   = arb_sel;
          x1_d    = !arb_sel;
          x2_d    = arb_sel;
          tmr_d   = TW'(1);
        end
      XC_GRANT:
        if (cur == XFERRING) begin
          state_d = XC_XFER;
          x1_d    = 1'b0;
          x2_d    = 1'b0;
        end else if (tmr_q == TW'(GRANT_TIMEOUT)) begin
          state_d = XC_COOL;
          x1_d    = 1'b0;
          x2_d    = 1'b0;
          to_d    = 1'b1;
          cool_d  = CW'(1);
          upd     = 1'b1;
        end else tmr_d = tmr_q + 1'b1;
      XC_XFER:
        if (cur != XFERRING) begin
          state_d = XC_COOL;
          cool_d  = CW'(1);
          upd     = 1'b1;
        end
      default:
        if (cool_q == CW'(COOLDOWN_CYCLES)) state_d = XC_IDLE;
        else cool_d = cool_q + 1'b1;
    endcase
  end

  // FSM state, timers and registered grant outputs.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= XC_IDLE;
      tmr_q   <= '0;
      cool_q  <= '0;
      sel_q   <= 1'b0;
      x1_q    <= 1'b0;
      x2_q    <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      cool_q  <= cool_d;
      sel_q   <= sel_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      to_q    <= to_d;
    end

  // Cross-coupled requests: each scanner sees the other's request one cycle late.
  always_ff @(posedge clk or negedge reset)
    if (!reset) xc_q <= '0;
    else xc_q <= {bus.goto_stby_out1, bus.goto_stby_out2, bus.start_scan_out1, bus.start_scan_out2};

  assign bus.xfer1          = x1_q;
  assign bus.xfer2          = x2_q;
  assign bus.start_scan_in1 = xc_q[0];
  assign bus.start_scan_in2 = xc_q[1];
  assign bus.goto_stby_in1  = xc_q[2];
  assign bus.goto_stby_in2  = xc_q[3];
  assign bus.busy           = state_q != XC_IDLE;
  assign bus.active_sel     = sel_q;
  assign bus.timeout_err    = to_q;

`ifdef SCAN_XFER_CTRL_STATS_EN
  logic [7:0]         cnt_q;
  logic [TOTAL_W-1:0] tot_q;
  logic [TOTAL_W:0]   sum;
  assign sum = {1'b0, tot_q} + (TOTAL_W + 1)'(cnt_q);
  // Unit count is latched when the transfer starts and added, saturating, when it ends.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt_q <= '0;
      tot_q <= '0;
    end else begin
      if (state_q == XC_GRANT && cur == XFERRING)
        cnt_q <= clamp_units(sel_q ? bus.mem_used2 : bus.mem_used1);
      if (state_q == XC_XFER && cur != XFERRING)
        tot_q <= sum[TOTAL_W] ? '1 : sum[TOTAL_W-1:0];
    end
  assign bus.xfer_total = tot_q;
`else
  assign bus.xfer_total = '0;
`endif
endmodule

// File: tb/tb_scan_xfer_ctrl.sv
// tb_scan_xfer_ctrl: randomized transfer sequences checked against a transaction-level model
module tb_scan_xfer_ctrl;
  import scanner_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   exp_total = 0;
  bit   last_g = 1'b1;
  logic [3:0] prev_x = '0;

  always #5 clk = ~clk;

  scan_xfer_ctrl_if #(.TOTAL_W(16)) bus ();

  scan_xfer_ctrl dut (.clk(clk), .reset(reset), .bus(bus.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit choose(bit e1, bit e2);
    return (e1 && e2) ? !last_g : e2;
  endfunction

  function automatic int sat(int a);
`ifdef SCAN_XFER_CTRL_STATS_EN
    return (a > 65535) ? 65535 : a;
`else
    return 0;
`endif
  endfunction

  task automatic tick();
    logic [3:0] r;
    @(posedge clk);
    #1;
    chk("xfer_excl", 32'(bus.xfer1 & bus.xfer2), 0);
    chk("start_scan_in1", 32'(bus.start_scan_in1), 32'(prev_x[1]));
    chk("start_scan_in2", 32'(bus.start_scan_in2), 32'(prev_x[0]));
    chk("goto_stby_in1", 32'(bus.goto_stby_in1), 32'(prev_x[3]));
    chk("goto_stby_in2", 32'(bus.goto_stby_in2), 32'(prev_x[2]));
    r = 4'($urandom);
    bus.start_scan_out1 = r[0];
    bus.start_scan_out2 = r[1];
    bus.goto_stby_out1  = r[2];
    bus.goto_stby_out2  = r[3];
    prev_x = r;
  endtask

  task automatic set_state(input bit s, input scan_state_e v);
    if (s) bus.state2 = v;
    else bus.state1 = v;
  endtask

  task automatic txn(input bit [1:0] pat, input int mem, input int dly, input int xlen, input bit tmo);
    bit s;
    bus.state1 = pat[0] ? IDLE : SCANNING;
    bus.state2 = pat[1] ? IDLE : SCANNING;
    bus.rdy_xfer1 = pat[0];
    bus.rdy_xfer2 = pat[1];
    bus.downlink_ok = 1'b1;
    s = choose(pat[0], pat[1]);
    tick();
    chk("grant_x1", 32'(bus.xfer1), 32'(!s));
    chk("grant_x2", 32'(bus.xfer2), 32'(s));
    chk("grant_sel", 32'(bus.active_sel), 32'(s));
    chk("grant_busy", 32'(bus.busy), 1);
    bus.rdy_xfer1 = 1'b0;
    bus.rdy_xfer2 = 1'b0;
    bus.downlink_ok = 1'b0;
    set_state(!s, SCANNING);
    set_state(s, IDLE);
    if (tmo) begin
      repeat (14) begin
        tick();
        chk("grant_hold", 32'(s ? bus.xfer2 : bus.xfer1), 1);
        chk("no_timeout", 32'(bus.timeout_err), 0);
      end
      tick();
      chk("timeout_drop", 32'(bus.xfer1 | bus.xfer2), 0);
      chk("timeout_pulse", 32'(bus.timeout_err), 1);
      chk("timeout_total", 32'(bus.xfer_total), 32'(exp_total));
    end else begin
      repeat (dly) begin
        tick();
        chk("grant_hold", 32'(s ? bus.xfer2 : bus.xfer1), 1);
      end
      set_state(s, XFERRING);
      if (s) bus.mem_used2 = 8'(mem);
      else bus.mem_used1 = 8'(mem);
      tick();
      chk("xfer_drop", 32'(bus.xfer1 | bus.xfer2), 0);
      chk("xfer_no_timeout", 32'(bus.timeout_err), 0);
      bus.mem_used1 = 8'($urandom_range(100));
      bus.mem_used2 = 8'($urandom_range(100));
      repeat (xlen - 1) begin
        tick();
        chk("xfer_busy", 32'(bus.busy), 1);
        chk("xfer_total_hold", 32'(bus.xfer_total), 32'(exp_total));
      end
      set_state(s, LOW_PWR);
      exp_total = sat(exp_total + mem);
      tick();
      chk("xfer_total", 32'(bus.xfer_total), 32'(exp_total));
    end
    last_g = s;
    bus.state1 = LOW_PWR;
    bus.state2 = LOW_PWR;
    repeat (3) begin
      tick();
      chk("cool_busy", 32'(bus.busy), 1);
      chk("cool_no_timeout", 32'(bus.timeout_err), 0);
      chk("cool_no_xfer", 32'(bus.xfer1 | bus.xfer2), 0);
    end
    tick();
    chk("cool_done", 32'(bus.busy), 0);
  endtask

  initial begin
    bus.state1 = LOW_PWR;
    bus.state2 = LOW_PWR;
    bus.mem_used1 = '0;
    bus.mem_used2 = '0;
    bus.rdy_xfer1 = 1'b0;
    bus.rdy_xfer2 = 1'b0;
    bus.start_scan_out1 = 1'b0;
    bus.start_scan_out2 = 1'b0;
    bus.goto_stby_out1 = 1'b0;
    bus.goto_stby_out2 = 1'b0;
    bus.downlink_ok = 1'b0;
    #12;
    chk("rst_xfer", 32'({bus.xfer1, bus.xfer2}), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_sel", 32'(bus.active_sel), 0);
    chk("rst_timeout", 32'(bus.timeout_err), 0);
    chk("rst_total", 32'(bus.xfer_total), 0);
    chk("rst_cross", 32'({bus.start_scan_in1, bus.start_scan_in2, bus.goto_stby_in1, bus.goto_stby_in2}), 0);
    @(posedge clk);
    #1 reset = 1'b1;

    txn(2'b11, 37, 2, 3, 0);
    txn(2'b11, 55, 0, 1, 0);
    txn(2'b01, 100, 1, 2, 0);
    txn(2'b10, 0, 0, 1, 1);
    txn(2'b11, 12, 3, 2, 0);

    bus.state1 = IDLE;
    bus.rdy_xfer1 = 1'b1;
    bus.downlink_ok = 1'b0;
    repeat (20) begin
      tick();
      chk("dl_off_xfer", 32'(bus.xfer1 | bus.xfer2), 0);
      chk("dl_off_busy", 32'(bus.busy), 0);
    end

    repeat (40)
      txn(2'($urandom_range(1, 3)), $urandom_range(100), $urandom_range(13),
          $urandom_range(1, 5), $urandom_range(4) == 0);

    bus.state1 = IDLE;
    bus.rdy_xfer1 = 1'b1;
    bus.downlink_ok = 1'b1;
    tick();
    chk("pre_rst_grant", 32'(bus.xfer1 | bus.xfer2), 1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_xfer", 32'(bus.xfer1 | bus.xfer2), 0);
    chk("async_rst_busy", 32'(bus.busy), 0);
    chk("async_rst_total", 32'(bus.xfer_total), 0);
    chk("async_rst_sel", 32'(bus.active_sel), 0);
    bus.state1 = LOW_PWR;
    bus.rdy_xfer1 = 1'b0;
    bus.start_scan_out1 = 1'b0;
    bus.start_scan_out2 = 1'b0;
    bus.goto_stby_out1 = 1'b0;
    bus.goto_stby_out2 = 1'b0;
    prev_x = '0;
    exp_total = 0;
    last_g = 1'b1;
    @(posedge clk);
    #1 reset = 1'b1;
    txn(2'b11, 64, 1, 1, 0);

`ifdef SCAN_XFER_CTRL_STATS_EN
    repeat (660) txn(2'b01, 100, 0, 1, 0);
    chk("saturated_total", 32'(bus.xfer_total), 65535);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
